// File: rtl/clk_tick_gen.sv
// Reset synchroniser, startup guard and programmable tick-enable generator.
// All logic runs on i_clk; downstream blocks use o_tick as a clock enable.
module clk_tick_gen #(
  parameter int unsigned DIV_W          = 32,
  parameter int unsigned DEFAULT_DIV    = 100000,
  parameter int unsigned STARTUP_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_div_value,
  output logic             o_rst_sync_n,
  output logic             o_ready,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_tick_cnt,
  output logic [DIV_W-1:0] o_div_active
);

  localparam int unsigned GUARD_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
  localparam logic [DIV_W-1:0] DivDefault = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {StSync, StGuard, StIdle, StRun} state_e;

  state_e             r_state, w_state_next;
  logic [1:0]         r_sync;
  logic [GUARD_W-1:0] r_guard;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   r_div_active;
  logic [DIV_W-1:0]   r_shadow;
  logic               r_pend;
  logic               r_tick;
  logic [CNT_W-1:0]   r_tick_cnt;

  logic               w_guard_done;
  logic               w_wrap;
  logic               w_load_ok;
  logic               w_apply;
  logic [DIV_W-1:0]   w_div_clamped;

  // Async assert, release two edges after i_rst_n rises
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], 1'b1};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StSync;
    else          r_state <= w_state_next;
  end

  assign w_guard_done = (r_guard == GUARD_W'(STARTUP_CYCLES - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StSync:  if (r_sync[1])    w_state_next = StGuard;
      StGuard: if (w_guard_done) w_state_next = StIdle;
      StIdle:  if (i_run)        w_state_next = StRun;
      StRun:   if (!i_run)       w_state_next = StIdle;
      default:                   w_state_next = StSync;
    endcase
  end

  always_comb begin
    o_ready = (r_state == StIdle) || (r_state == StRun);
  end

  assign w_wrap        = (r_state == StRun) && i_run && (r_div_cnt == (r_div_active - DivOne));
  assign w_load_ok     = i_div_load && ((r_state == StIdle) || (r_state == StRun));
  // A pending divisor lands immediately when idle, otherwise only at a period boundary
  assign w_apply       = r_pend && ((r_state == StIdle) || w_wrap);
  assign w_div_clamped = (i_div_value == '0) ? DivOne : i_div_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_guard      <= '0;
      r_div_cnt    <= '0;
      r_div_active <= DivDefault;
      r_shadow     <= DivDefault;
      r_pend       <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_cnt   <= '0;
    end else begin
      r_guard   <= (r_state == StGuard) ? r_guard + GUARD_W'(1) : '0;
      r_div_cnt <= ((r_state == StRun) && i_run && !w_wrap) ? r_div_cnt + DivOne : '0;
      r_tick    <= w_wrap;
      if (w_wrap) r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      if (w_apply) r_div_active <= r_shadow;
      if (w_load_ok) begin
        r_shadow <= w_div_clamped;
        r_pend   <= 1'b1;
      end else if (w_apply) begin
        r_pend   <= 1'b0;
      end
    end
  end

  assign o_rst_sync_n = r_sync[1];
  assign o_tick       = r_tick;
  assign o_tick_cnt   = r_tick_cnt;
  assign o_div_active = r_div_active;

endmodule
